uart_tx_serializer: RTL and testbench

//  CPU-side serial transmitter; the outbound counterpart of the CPU's rx loader path.

---
 rtl/uart_tx_serializer.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module  : uart_tx_serializer
// Brief   : Serial TX: start, DBIT data bits LSB first, even parity, stop.
//           Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry input buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_serializer #(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TW-1:0] c_timer_last   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] c_timer_penult = TW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] c_bit_last     = BW'(DBIT - 1);

  if (DBIT < 1 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 1 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_serializer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [BW-1:0]   bitcnt_q;
  logic [DBIT-1:0] shreg_q;
  logic            parity_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;

  logic            w_timer_last;
  logic            w_load;
  logic [DBIT-1:0] w_load_data;
  logic [DBIT-1:0] w_shift;

  assign w_timer_last = (timer_q == c_timer_last);
  assign w_shift      = shreg_q >> 1;

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DBIT-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            w_full;
  logic            w_empty;
  logic            w_push;

  assign w_full      = (count_q == CW'(FIFO_DEPTH));
  assign w_empty     = (count_q == '0);
  assign tx_ready    = !w_full;
  assign w_push      = tx_valid && !w_full;
  // Pop either from idle or on the final stop cycle, so frames run back to back.
  assign w_load      = !w_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && w_timer_last));
  assign w_load_data = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) fifo_mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (w_load) rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(w_push) - CW'(w_load);
    end
  end
`else
  assign tx_ready    = (state_q == S_IDLE);
  assign w_load      = (state_q == S_IDLE) && tx_valid;
  assign w_load_data = tx_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      timer_q <= ((state_q == S_IDLE) || w_timer_last) ? '0 : timer_q + 1'b1;
      // Raised one edge early so the pulse lands on the final stop cycle.
      done_q  <= (state_q == S_STOP) && (timer_q == c_timer_penult);
      case (state_q)
        S_IDLE: begin
          if (w_load) begin
            shreg_q  <= w_load_data;
            parity_q <= ^w_load_data;
            state_q  <= S_START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (w_timer_last) begin
            state_q  <= S_DATA;
            bitcnt_q <= '0;
            tx_q     <= shreg_q[0];
          end
        end
        S_DATA: begin
          if (w_timer_last) begin
            if (bitcnt_q == c_bit_last) begin
              state_q <= S_PARITY;
              tx_q    <= parity_q;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
              shreg_q  <= w_shift;
              tx_q     <= w_shift[0];
            end
          end
        end
        S_PARITY: begin
          if (w_timer_last) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_timer_last) begin
            if (w_load) begin
              shreg_q  <= w_load_data;
              parity_q <= ^w_load_data;
              state_q  <= S_START;
              tx_q     <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module  : tb_uart_tx_serializer
// Brief   : Directed bench for uart_tx_serializer (DBIT=8, CLKS_PER_BIT=16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;

  localparam int DBIT  = 8;
  localparam int CPB   = 16;
  localparam int FRAME = (DBIT + 3) * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_serializer #(
    .DBIT        (DBIT),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for tx_ready, then presents one byte for a single accepting edge.
  task automatic send(input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(posedge clk);
    #1;
`endif
  endtask

  // Samples cycles skip+1..FRAME of a frame whose start edge has just passed.
  task automatic run_frame(input logic [7:0] d, input int skip, input bit scramble);
    logic [10:0] exp_bits;
    int done_at;
    int n_done;
    int ready_hi;
    exp_bits = {1'b1, ^d, d, 1'b0};
    done_at  = 0;
    n_done   = 0;
    ready_hi = 0;
    for (int c = skip + 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (c == skip + 1) chk("busy_first", busy, 1);
      if ((c - 1) % CPB == 7)
        chk($sformatf("tx_%02h_bit%0d", d, (c - 1) / CPB), tx, exp_bits[(c - 1) / CPB]);
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      if (tx_ready) ready_hi++;
      if (scramble) tx_data = 8'($urandom);
    end
    chk($sformatf("done_cycle_%02h", d), done_at, FRAME);
    chk($sformatf("done_count_%02h", d), n_done, 1);
`ifndef UART_TX_FIFO_EN
    chk($sformatf("ready_low_%02h", d), ready_hi, 0);
`endif
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_tx"}, tx, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", tx_ready, 1);
    chk("rel_tx", tx, 1);

    // Basic frames, including odd and zero parity
    send(8'hA5);
    run_frame(8'hA5, 0, 1'b0);
    idle_chk("idle_a5");
    send(8'h07);
    run_frame(8'h07, 0, 1'b0);
    idle_chk("idle_07");
    send(8'h00);
    run_frame(8'h00, 0, 1'b0);
    idle_chk("idle_00");

`ifndef UART_TX_FIFO_EN
    // Held valid with changing data: first byte framed, next accepted one cycle after done
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    run_frame(8'h5A, 0, 1'b1);
    @(negedge clk);
    chk("gap_ready", tx_ready, 1);
    chk("gap_tx", tx, 1);
    chk("gap_busy", busy, 0);
    tx_data = 8'hC3;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    run_frame(8'hC3, 0, 1'b0);
    idle_chk("idle_c3");
`endif

    // Asynchronous reset in data bit 3 aborts the frame
    send(8'h96);
    for (int c = 1; c <= 70; c++) @(negedge clk);
    chk("pre_rst_bit3", tx, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_done", done, 0);
    end
    reset = 1'b1;
    send(8'h3C);
    run_frame(8'h3C, 0, 1'b0);
    idle_chk("idle_3c");

`ifdef UART_TX_FIFO_EN
    // Five back-to-back pushes, sixth blocked, contiguous frames
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("push%0d_ready", i), tx_ready, 1);
      tx_data  = 8'(8'h11 + i);
      tx_valid = 1'b1;
    end
    @(posedge clk);
    #1 tx_data = 8'h16;
    @(negedge clk);
    chk("push5_blocked", tx_ready, 0);
    tx_valid = 1'b0;
    run_frame(8'h11, 4, 1'b0);
    for (int i = 1; i < 5; i++) run_frame(8'(8'h11 + i), 0, 1'b0);
    idle_chk("idle_fifo");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
